// File: rtl/led_pattern_seq_if.sv
// Signal bundle between the LED pattern sequencer and its controller.
// With LED_PWM_EN defined the bundle also carries the 4-bit duty input.
interface led_pattern_seq_if;
    logic       en;
    logic [1:0] mode;
`ifdef LED_PWM_EN
    logic [3:0] duty;
`endif
    logic       step;
    logic       LED0;
    logic       LED1;
    logic       LED2;
    logic       LED3;

`ifdef LED_PWM_EN
    modport master (output en, mode, duty, input step, LED0, LED1, LED2, LED3);
    modport slave  (input en, mode, duty, output step, LED0, LED1, LED2, LED3);
`else
    modport master (output en, mode, input step, LED0, LED1, LED2, LED3);
    modport slave  (input en, mode, output step, LED0, LED1, LED2, LED3);
`endif
endinterface

// File: rtl/led_pattern_seq.sv
// Four-LED pattern sequencer: prescaled step of COUNT/ROTATE/BOUNCE/BLINK patterns.
// Optional macro LED_PWM_EN adds duty-cycle dimming with registered LED outputs.
module led_pattern_seq #(
    parameter int DIV = 3000000
) (
    input  logic             clk,
    input  logic             rst,
    led_pattern_seq_if.slave bus
);
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    localparam logic [1:0] M_COUNT  = 2'd0;
    localparam logic [1:0] M_ROTATE = 2'd1;
    localparam logic [1:0] M_BOUNCE = 2'd2;

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_mode_q;
    logic [3:0]       r_pat;
    logic             r_dir_down;
    logic             r_step;

    logic [3:0]       w_pat_next;
    logic             w_dir_next;
    logic             w_mode_chg;
    logic             w_wrap;

    function automatic logic [3:0] init_pat(input logic [1:0] m);
        return (m == M_ROTATE || m == M_BOUNCE) ? 4'b0001 : 4'b0000;
    endfunction

    assign w_mode_chg = (bus.mode != r_mode_q);
    assign w_wrap     = bus.en && (r_cnt == CNT_MAX);

    always_comb begin
        w_pat_next = r_pat;
        w_dir_next = r_dir_down;
        case (r_mode_q)
            M_COUNT:  w_pat_next = r_pat + 4'd1;
            M_ROTATE: w_pat_next = {r_pat[2:0], r_pat[3]};
            M_BOUNCE: begin
                // Reverse at the ends so neither end value is shown twice
                if (!r_dir_down) begin
                    if (r_pat[3]) begin
                        w_pat_next = 4'b0100;
                        w_dir_next = 1'b1;
                    end else begin
                        w_pat_next = {r_pat[2:0], 1'b0};
                    end
                end else begin
                    if (r_pat[0]) begin
                        w_pat_next = 4'b0010;
                        w_dir_next = 1'b0;
                    end else begin
                        w_pat_next = {1'b0, r_pat[3:1]};
                    end
                end
            end
            default:  w_pat_next = ~r_pat;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_mode_q   <= M_COUNT;
            r_pat      <= 4'b0000;
            r_dir_down <= 1'b0;
            r_step     <= 1'b0;
        end else if (w_mode_chg) begin
            // A mode change restarts the sequence and swallows a coincident step
            r_mode_q   <= bus.mode;
            r_pat      <= init_pat(bus.mode);
            r_cnt      <= '0;
            r_dir_down <= 1'b0;
            r_step     <= 1'b0;
        end else begin
            r_step <= w_wrap;
            if (w_wrap) begin
                r_cnt      <= '0;
                r_pat      <= w_pat_next;
                r_dir_down <= w_dir_next;
            end else if (bus.en) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.step = r_step;

`ifdef LED_PWM_EN
    logic [3:0] r_pwm;
    logic [3:0] r_led;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm <= 4'd0;
            r_led <= 4'b0000;
        end else begin
            r_pwm <= r_pwm + 4'd1;
            r_led <= r_pat & {4{r_pwm < bus.duty}};
        end
    end

    assign bus.LED0 = r_led[0];
    assign bus.LED1 = r_led[1];
    assign bus.LED2 = r_led[2];
    assign bus.LED3 = r_led[3];
`else
    assign bus.LED0 = r_pat[0];
    assign bus.LED1 = r_pat[1];
    assign bus.LED2 = r_pat[2];
    assign bus.LED3 = r_pat[3];
`endif
endmodule

// File: tb/tb_led_pattern_seq.sv
// Scoreboard bench for led_pattern_seq (DIV=4): stimulus queues expected steps and
// mid-cycle probes; one monitor on the falling edge does every comparison.
module tb_led_pattern_seq;
    typedef struct {
        int         cyc;
        logic [3:0] leds;
        logic       stp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   done = 1'b0;
    exp_t stepq[$];
    exp_t probeq[$];
    logic [3:0] w_leds;

    led_pattern_seq_if bus ();

    led_pattern_seq #(.DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign w_leds = {bus.LED3, bus.LED2, bus.LED1, bus.LED0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic go_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_step(input int c, input logic [3:0] l);
        stepq.push_back('{c, l, 1'b1});
    endtask

    task automatic exp_probe(input int c, input logic [3:0] l, input logic s);
        probeq.push_back('{c, l, s});
    endtask

    // Monitor: all comparisons happen here, away from the rising edge
    always @(negedge clk) begin
        exp_t e;
        if (probeq.size() != 0 && probeq[0].cyc == cyc) begin
            e = probeq.pop_front();
            checks++;
            if (w_leds !== e.leds || bus.step !== e.stp) begin
                failures++;
                $display("FAIL probe cyc=%0d got leds=%b step=%b want leds=%b step=%b",
                         cyc, w_leds, bus.step, e.leds, e.stp);
            end
        end
        if (bus.step === 1'b1) begin
            checks++;
            if (stepq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_step cyc=%0d leds=%b want no step", cyc, w_leds);
            end else begin
                e = stepq.pop_front();
                if (e.cyc != cyc || w_leds !== e.leds) begin
                    failures++;
                    $display("FAIL step got cyc=%0d leds=%b want cyc=%0d leds=%b",
                             cyc, w_leds, e.cyc, e.leds);
                end
            end
        end
        if (done) begin
            checks++;
            if (stepq.size() != 0 || probeq.size() != 0) begin
                failures++;
                $display("FAIL leftover got steps=%0d probes=%0d want 0 0",
                         stepq.size(), probeq.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        int r, s, t, u, v;
        logic [3:0] bnc [7];
        bnc = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        rst      = 1'b1;
        bus.en   = 1'b1;
        bus.mode = 2'd0;
`ifdef LED_PWM_EN
        bus.duty = 4'd15;
`endif
        // Reset state and COUNT with wrap after 16 steps
        exp_probe(2, 4'b0000, 1'b0);
        go_to(3);
        rst = 1'b0;
        r = cyc;
        exp_probe(r + 3, 4'b0000, 1'b0);
        for (int n = 1; n <= 16; n++) exp_step(r + 4 * n, 4'(n));

        // BOUNCE: init 0001, no repeat at either end
        go_to(r + 66);
        s = cyc;
        bus.mode = 2'd2;
        exp_probe(s + 1, 4'b0001, 1'b0);
        for (int k = 0; k < 7; k++) exp_step(s + 1 + 4 * (k + 1), bnc[k]);

        // ROTATE with en held low for 10 cycles at cnt=2
        go_to(s + 31);
        t = cyc;
        bus.mode = 2'd1;
        exp_step(t + 5, 4'b0010);
        exp_step(t + 9, 4'b0100);
        go_to(t + 11);
        bus.en = 1'b0;
        for (int i = 1; i <= 10; i++) exp_probe(t + 11 + i, 4'b0100, 1'b0);
        go_to(t + 21);
        bus.en = 1'b1;
        exp_probe(t + 22, 4'b0100, 1'b0);
        exp_step(t + 23, 4'b1000);
        exp_step(t + 27, 4'b0001);

        // Mode change 0 -> 3 on the edge where cnt==3 suppresses the step
        go_to(t + 29);
        u = cyc;
        bus.mode = 2'd0;
        exp_step(u + 5, 4'b0001);
        go_to(u + 8);
        bus.mode = 2'd3;
        exp_probe(u + 9, 4'b0000, 1'b0);
        exp_step(u + 13, 4'b1111);
        exp_step(u + 17, 4'b0000);
        exp_step(u + 21, 4'b1111);

        // Asynchronous reset mid-cycle while LEDs show 1111
        go_to(u + 22);
        exp_probe(u + 22, 4'b0000, 1'b0);
        #2;
        rst = 1'b1;
        go_to(u + 25);
        rst = 1'b0;
        v = cyc;
        exp_probe(v + 1, 4'b0000, 1'b0);
        exp_step(v + 5, 4'b1111);
        exp_step(v + 9, 4'b0000);
        go_to(v + 11);
        done = 1'b1;
    end

    initial begin
        #20000;
        $display("FAIL timeout cyc=%0d want finish before 20000ns", cyc);
        $fatal(1, "timeout");
    end
endmodule
